// File: rtl/irq_requester.sv
// ---------------------------------------------------------------------------
// irq_requester
//   Peripheral-side interrupt source feeding the control unit's int_in lines.
//   Each line queues device events in a saturating counter, raises a pulse of
//   PULSE_LEN cycles on int_out[i], waits for the acknowledge strobe coming
//   back from the control unit, and re-raises the request if no acknowledge
//   arrives within TIMEOUT cycles. After an accepted acknowledge the line is
//   held off for GAP_LEN cycles before it may request again.
//
// Ports
//   clk           system clock, all state on posedge
//   rst           asynchronous reset, active-high
//   event_in      per-line device event (one event per high cycle)
//   ack_in        per-line acknowledge strobe (RST_INT_i)
//   overflow_clr  per-line clear of the sticky overflow flag
//   int_out       per-line registered set pulse towards the int latch
//   pending       per-line "counter not empty"
//   overflow      per-line sticky "event dropped at saturation"
//   retry_cnt     total timeouts over all lines, saturating at 255
// ---------------------------------------------------------------------------
module irq_requester #(
    parameter int N_LINES   = 5,
    parameter int CNT_W     = 3,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LINES-1:0] event_in,
    input  logic [N_LINES-1:0] ack_in,
    input  logic [N_LINES-1:0] overflow_clr,
    output logic [N_LINES-1:0] int_out,
    output logic [N_LINES-1:0] pending,
    output logic [N_LINES-1:0] overflow,
    output logic [7:0]         retry_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT,
        ST_GAP
    } state_t;

    // One timer per line is reused for pulse, timeout and gap phases, so it
    // is sized for the longest of the three.
    localparam int TMAX_A = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TMAX   = (TMAX_A > TIMEOUT) ? TMAX_A : TIMEOUT;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]    T_PULSE = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0]    T_GAP   = TW'(GAP_LEN - 1);
    localparam logic [TW-1:0]    T_WAIT  = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_LINES-1:0] timeout_hit;

    generate
        for (genvar gi = 0; gi < N_LINES; gi++) begin : g_line
            state_t           state_reg, state_next;
            logic [TW-1:0]    timer_reg, timer_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             ovf_reg, ovf_next;
            logic             int_reg;
            logic             ack_ok;
            logic             inc;
            logic             drop;
            logic             hit;

            // Event counter and overflow flag. An acknowledge is only
            // accepted while a request is outstanding, which guarantees the
            // counter is non-zero whenever it decrements.
            always_comb begin
                ack_ok   = ack_in[gi] && ((state_reg == ST_ASSERT) || (state_reg == ST_WAIT));
                inc      = event_in[gi];
                drop     = inc && !ack_ok && (cnt_reg == CNT_MAX);
                cnt_next = cnt_reg;
                if (inc && !ack_ok && !drop) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end else if (ack_ok && !inc) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
                // A drop in the same cycle as a clear wins, so no lost event
                // goes unreported.
                if (drop) begin
                    ovf_next = 1'b1;
                end else if (overflow_clr[gi]) begin
                    ovf_next = 1'b0;
                end else begin
                    ovf_next = ovf_reg;
                end
            end

            // Request handshake FSM.
            always_comb begin
                state_next = state_reg;
                timer_next = timer_reg;
                hit        = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (cnt_reg != '0) begin
                            state_next = ST_ASSERT;
                            timer_next = T_PULSE;
                        end
                    end
                    ST_ASSERT: begin
                        if (ack_ok) begin
                            state_next = ST_GAP;
                            timer_next = T_GAP;
                        end else if (timer_reg == '0) begin
                            state_next = ST_WAIT;
                            timer_next = T_WAIT;
                        end else begin
                            timer_next = timer_reg - TW'(1);
                        end
                    end
                    ST_WAIT: begin
                        if (ack_ok) begin
                            state_next = ST_GAP;
                            timer_next = T_GAP;
                        end else if (timer_reg == '0) begin
                            // Retry: the event stays queued, pulse again.
                            state_next = ST_ASSERT;
                            timer_next = T_PULSE;
                            hit        = 1'b1;
                        end else begin
                            timer_next = timer_reg - TW'(1);
                        end
                    end
                    ST_GAP: begin
                        if (timer_reg == '0) begin
                            state_next = ST_IDLE;
                        end else begin
                            timer_next = timer_reg - TW'(1);
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        timer_next = '0;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= ST_IDLE;
                    timer_reg <= '0;
                    cnt_reg   <= '0;
                    ovf_reg   <= 1'b0;
                    int_reg   <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    timer_reg <= timer_next;
                    cnt_reg   <= cnt_next;
                    ovf_reg   <= ovf_next;
                    // Registered from the next state so int_out is a flop
                    // output that is high exactly while the line is in ASSERT.
                    int_reg   <= (state_next == ST_ASSERT);
                end
            end

            assign int_out[gi]     = int_reg;
            assign pending[gi]     = (cnt_reg != '0);
            assign overflow[gi]    = ovf_reg;
            assign timeout_hit[gi] = hit;
        end
    endgenerate

    // Global retry counter: several lines may time out in one cycle.
    logic [7:0]  retry_reg;
    logic [15:0] retry_sum;
    logic [7:0]  retry_next;

    always_comb begin
        retry_sum = {8'd0, retry_reg};
        for (int i = 0; i < N_LINES; i++) begin
            retry_sum = retry_sum + {15'd0, timeout_hit[i]};
        end
        retry_next = (retry_sum > 16'd255) ? 8'hFF : retry_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_reg <= 8'd0;
        end else begin
            retry_reg <= retry_next;
        end
    end

    assign retry_cnt = retry_reg;

endmodule

// File: tb/tb_irq_requester.sv
// ---------------------------------------------------------------------------
// tb_irq_requester
//   Directed testbench for irq_requester with default parameters. Inputs are
//   driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_irq_requester;

    logic       clk;
    logic       rst;
    logic [4:0] event_in;
    logic [4:0] ack_in;
    logic [4:0] overflow_clr;
    logic [4:0] int_out;
    logic [4:0] pending;
    logic [4:0] overflow;
    logic [7:0] retry_cnt;

    int checks;
    int errors;

    irq_requester dut (
        .clk          (clk),
        .rst          (rst),
        .event_in     (event_in),
        .ack_in       (ack_in),
        .overflow_clr (overflow_clr),
        .int_out      (int_out),
        .pending      (pending),
        .overflow     (overflow),
        .retry_cnt    (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        event_in     = '0;
        ack_in       = '0;
        overflow_clr = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        event_in     = '0;
        ack_in       = '0;
        overflow_clr = '0;
        step();
        step();
        checks++;
        if ({int_out, pending, overflow, retry_cnt} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {int_out, pending, overflow, retry_cnt});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({int_out, pending, overflow, retry_cnt} !== 23'd0) begin
            errors++;
            $display("FAIL reset_release got=%h exp=0", {int_out, pending, overflow, retry_cnt});
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int bad;
        apply_reset();
        event_in[0] = 1'b1;
        step();                        // E1: counter 1
        event_in[0] = 1'b0;
        checks++;
        if (int_out[0] !== 1'b0 || pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_e1 int=%b pend=%b exp int=0 pend=1", int_out[0], pending[0]);
        end
        step();                        // E2: ASSERT
        checks++;
        if (int_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_hi1 int=%b exp=1", int_out[0]);
        end
        step();                        // E3
        checks++;
        if (int_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_hi2 int=%b exp=1", int_out[0]);
        end
        step();                        // E4: WAIT_ACK
        checks++;
        if (int_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_lo int=%b exp=0", int_out[0]);
        end
        ack_in[0] = 1'b1;
        step();                        // E5: ack accepted
        ack_in[0] = 1'b0;
        checks++;
        if (pending[0] !== 1'b0 || int_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_ack pend=%b int=%b exp 0 0", pending[0], int_out[0]);
        end
        bad = 0;
        repeat (10) begin
            step();
            if (int_out !== 5'd0 || retry_cnt !== 8'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_quiet bad_cycles=%0d exp=0", bad);
        end
        $display("test_single done");
    endtask

    task automatic test_back_to_back();
        int pulses, hi, lo;
        logic cur, prev;
        apply_reset();
        event_in[2] = 1'b1;
        step();                        // E1
        pulses = 0; hi = 0; lo = 0; prev = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            cur = int_out[2];
            if (cur && !prev) begin
                if (pulses > 0) begin
                    checks++;
                    if (lo != 4) begin
                        errors++;
                        $display("FAIL b2b_gap pulse=%0d low=%0d exp=4", pulses, lo);
                    end
                end
                hi = 0;
            end
            if (!cur && prev) begin
                checks++;
                if (hi != 2) begin
                    errors++;
                    $display("FAIL b2b_width pulse=%0d high=%0d exp=2", pulses, hi);
                end
                pulses++;
                lo = 0;
            end
            ack_in[2] = !cur && prev;
            if (cur) hi++;
            else lo++;
            prev = cur;
            if (cyc == 3) event_in[2] = 1'b0;
            step();
        end
        ack_in[2] = 1'b0;
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL b2b_count pulses=%0d exp=3", pulses);
        end
        checks++;
        if (pending[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pending got=%b exp=0", pending[2]);
        end
        $display("test_back_to_back done pulses=%0d", pulses);
    endtask

    task automatic test_overflow();
        int acks;
        apply_reset();
        event_in[4] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 7) begin
                checks++;
                if (overflow[4] !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_at7 got=%b exp=0", overflow[4]);
                end
            end
            if (k == 8) begin
                checks++;
                if (overflow[4] !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_at8 got=%b exp=1", overflow[4]);
                end
            end
        end
        overflow_clr[4] = 1'b1;        // clear colliding with a dropped event
        step();
        checks++;
        if (overflow[4] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clr_collide got=%b exp=1", overflow[4]);
        end
        event_in[4] = 1'b0;
        step();
        overflow_clr[4] = 1'b0;
        checks++;
        if (overflow[4] !== 1'b0 || pending[4] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clr ovf=%b pend=%b exp ovf=0 pend=1", overflow[4], pending[4]);
        end
        acks = 0;
        for (int n = 0; n < 400 && acks < 7; n++) begin
            if (int_out[4] === 1'b1) begin
                ack_in[4] = 1'b1;
                step();
                ack_in[4] = 1'b0;
                acks++;
                if (acks == 6) begin
                    checks++;
                    if (pending[4] !== 1'b1) begin
                        errors++;
                        $display("FAIL ovf_drain6 pend=%b exp=1", pending[4]);
                    end
                end
            end else begin
                step();
            end
        end
        checks++;
        if (acks != 7 || pending[4] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain7 acks=%0d pend=%b exp acks=7 pend=0", acks, pending[4]);
        end
        $display("test_overflow done acks=%0d", acks);
    endtask

    task automatic test_retry();
        int rises;
        logic prev;
        apply_reset();
        event_in[1] = 1'b1;
        step();                        // E1
        event_in[1] = 1'b0;
        rises = 0;
        prev  = 1'b0;
        for (int cyc = 1; cyc <= 140; cyc++) begin
            if (cyc == 67) begin
                checks++;
                if (retry_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL retry_before got=%0d exp=0", retry_cnt);
                end
            end
            if (int_out[1] && !prev) begin
                checks++;
                if (cyc != 2 + 66 * rises || retry_cnt !== 8'(rises)) begin
                    errors++;
                    $display("FAIL retry_rise n=%0d cyc=%0d exp_cyc=%0d retry=%0d exp=%0d",
                             rises, cyc, 2 + 66 * rises, retry_cnt, rises);
                end
                rises++;
            end
            prev = int_out[1];
            step();
        end
        checks++;
        if (rises != 3) begin
            errors++;
            $display("FAIL retry_count rises=%0d exp=3", rises);
        end
        $display("test_retry done rises=%0d", rises);
    endtask

    task automatic test_retry_saturate();
        apply_reset();
        event_in = 5'h1F;
        step();                        // E1 on all lines
        event_in = 5'h00;
        for (int cyc = 1; cyc <= 3600; cyc++) begin
            if (cyc == 68) begin
                checks++;
                if (retry_cnt !== 8'd5) begin
                    errors++;
                    $display("FAIL sat_first got=%0d exp=5", retry_cnt);
                end
            end
            if (cyc == 3302) begin
                checks++;
                if (retry_cnt !== 8'd250) begin
                    errors++;
                    $display("FAIL sat_250 got=%0d exp=250", retry_cnt);
                end
            end
            if (cyc == 3600) begin
                checks++;
                if (retry_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_255 got=%0d exp=255", retry_cnt);
                end
            end
            step();
        end
        $display("test_retry_saturate done retry=%0d", retry_cnt);
    endtask

    task automatic test_event_with_ack();
        apply_reset();
        event_in[3] = 1'b1;
        step();                        // E1
        event_in[3] = 1'b0;
        step();                        // E2: ASSERT
        checks++;
        if (int_out[3] !== 1'b1) begin
            errors++;
            $display("FAIL coll_hi got=%b exp=1", int_out[3]);
        end
        event_in[3] = 1'b1;
        ack_in[3]   = 1'b1;
        step();                        // E3: inc and dec together
        event_in[3] = 1'b0;
        ack_in[3]   = 1'b0;
        checks++;
        if (pending[3] !== 1'b1 || int_out[3] !== 1'b0) begin
            errors++;
            $display("FAIL coll_hold pend=%b int=%b exp pend=1 int=0", pending[3], int_out[3]);
        end
        step();                        // E4: GAP
        step();                        // E5: IDLE
        checks++;
        if (int_out[3] !== 1'b0) begin
            errors++;
            $display("FAIL coll_gap got=%b exp=0", int_out[3]);
        end
        step();                        // E6: ASSERT again
        checks++;
        if (int_out[3] !== 1'b1) begin
            errors++;
            $display("FAIL coll_repulse got=%b exp=1", int_out[3]);
        end
        ack_in[3] = 1'b1;
        step();
        ack_in[3] = 1'b0;
        checks++;
        if (pending[3] !== 1'b0) begin
            errors++;
            $display("FAIL coll_drain got=%b exp=0", pending[3]);
        end
        $display("test_event_with_ack done");
    endtask

    task automatic test_async_reset();
        int bad;
        apply_reset();
        event_in[0] = 1'b1;
        step();
        event_in[0] = 1'b0;
        step();
        checks++;
        if (int_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre got=%b exp=1", int_out[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (int_out !== 5'd0 || pending !== 5'd0) begin
            errors++;
            $display("FAIL arst_drop int=%b pend=%b exp 0 0", int_out, pending);
        end
        step();
        step();
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            step();
            if ({int_out, pending, overflow, retry_cnt} !== 23'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL arst_quiet bad_cycles=%0d exp=0", bad);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        event_in     = '0;
        ack_in       = '0;
        overflow_clr = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_retry();
        test_retry_saturate();
        test_event_with_ack();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
